// File: rtl/jpeg_block_sequencer.sv
// -----------------------------------------------------------------------------
// jpeg_block_sequencer
//
// Phase sequencer for the JPEG encoder datapath. A configured number of blocks
// is walked through three phases per block: pixel read, forward DCT and
// entropy encode. All outputs are qualified enables, never gated clocks. Read
// and encode advance only on valid/ready handshakes, so upstream or downstream
// stalls simply hold the sequencer in place.
//
// Optional feature: define JPEG_SEQ_ABORT_EN to add an 'abort' input. It
// returns an active run to IDLE on the next cycle without pulsing done.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-low reset
//   conf_en     load cfg_blocks into the stored block count (IDLE only)
//   cfg_blocks  number of blocks per run; 0 means nothing to do
//   comp_en     start a run (IDLE only, ignored when the stored count is 0)
//   in_valid    read buffer presents a pixel this cycle
//   enc_ready   encoder accepts a coefficient this cycle
//   abort       (JPEG_SEQ_ABORT_EN only) cancel the current run
//   read_en     pixel accepted this cycle
//   dct_en      DCT stage active
//   encode_en   coefficient issued to the encoder this cycle
//   pix_idx     pixel/coefficient index within the current block
//   blk_left    blocks remaining, including the current one
//   busy        sequencer is not IDLE
//   done        one-cycle pulse after the last block has been encoded
// -----------------------------------------------------------------------------
module jpeg_block_sequencer #(
  parameter int unsigned PIX_PER_BLK = 64,
  parameter int unsigned DCT_LAT     = 3,
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned IDX_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             conf_en,
  input  logic [CNT_W-1:0] cfg_blocks,
  input  logic             comp_en,
  input  logic             in_valid,
  input  logic             enc_ready,
`ifdef JPEG_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             read_en,
  output logic             dct_en,
  output logic             encode_en,
  output logic [IDX_W-1:0] pix_idx,
  output logic [CNT_W-1:0] blk_left,
  output logic             busy,
  output logic             done
);

  localparam int unsigned DCT_W = (DCT_LAT > 1) ? $clog2(DCT_LAT) : 1;
  localparam logic [IDX_W-1:0] PIX_LAST = IDX_W'(PIX_PER_BLK - 1);
  localparam logic [DCT_W-1:0] DCT_LAST = DCT_W'(DCT_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    CONF,
    READ,
    FDCT,
    ENCO
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   stored_blocks;
  logic [DCT_W-1:0]   dct_cnt;
  logic               abort_req;

`ifdef JPEG_SEQ_ABORT_EN
  // Abort only matters while a run is in flight; IDLE and CONF ignore it.
  assign abort_req = abort && (state == READ || state == FDCT || state == ENCO);
`else
  assign abort_req = 1'b0;
`endif

  // Handshake enables are combinational so a pixel/coefficient is accepted in
  // the same cycle the producer or consumer offers it.
  assign read_en   = (state == READ) && in_valid;
  assign encode_en = (state == ENCO) && enc_ready;
  assign dct_en    = (state == FDCT);
  assign busy      = (state != IDLE);

  // NOTE: state registers use non-blocking assignments so every register in
  // this block samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      stored_blocks <= '0;
      dct_cnt       <= '0;
      pix_idx       <= '0;
      blk_left      <= '0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort_req) begin
        // Stored count survives so the same job can be restarted directly.
        state    <= IDLE;
        pix_idx  <= '0;
        blk_left <= '0;
        dct_cnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (conf_en) begin
              stored_blocks <= cfg_blocks;
              state         <= CONF;
            end else if (comp_en && stored_blocks != '0) begin
              blk_left <= stored_blocks;
              pix_idx  <= '0;
              state    <= READ;
            end
          end
          CONF: state <= IDLE;
          READ: begin
            if (in_valid) begin
              if (pix_idx == PIX_LAST) begin
                pix_idx <= '0;
                dct_cnt <= '0;
                state   <= FDCT;
              end else begin
                pix_idx <= pix_idx + 1'b1;
              end
            end
          end
          FDCT: begin
            if (dct_cnt == DCT_LAST) begin
              dct_cnt <= '0;
              state   <= ENCO;
            end else begin
              dct_cnt <= dct_cnt + 1'b1;
            end
          end
          ENCO: begin
            if (enc_ready) begin
              if (pix_idx == PIX_LAST) begin
                pix_idx <= '0;
                if (blk_left == CNT_W'(1)) begin
                  blk_left <= '0;
                  done     <= 1'b1;
                  state    <= IDLE;
                end else begin
                  blk_left <= blk_left - 1'b1;
                  state    <= READ;
                end
              end else begin
                pix_idx <= pix_idx + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jpeg_block_sequencer.sv
// -----------------------------------------------------------------------------
// tb_jpeg_block_sequencer
//
// Self-checking bench. A transaction-level model (pixels read, DCT cycles
// spent and coefficients encoded in the current block, blocks remaining)
// predicts every output on every falling edge; directed scenarios add literal
// expectations for pulse counts, latency and block counts. Build with
// +define+JPEG_SEQ_ABORT_EN to exercise the abort path as well.
// -----------------------------------------------------------------------------
module tb_jpeg_block_sequencer;

  localparam int P     = 64;
  localparam int LAT   = 3;
  localparam int CNT_W = 24;
  localparam int IDX_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             conf_en;
  logic [CNT_W-1:0] cfg_blocks;
  logic             comp_en;
  logic             in_valid;
  logic             enc_ready;
  logic             abort;
  logic             read_en;
  logic             dct_en;
  logic             encode_en;
  logic [IDX_W-1:0] pix_idx;
  logic [CNT_W-1:0] blk_left;
  logic             busy;
  logic             done;

  jpeg_block_sequencer #(
    .PIX_PER_BLK(P),
    .DCT_LAT    (LAT),
    .CNT_W      (CNT_W),
    .IDX_W      (IDX_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .conf_en   (conf_en),
    .cfg_blocks(cfg_blocks),
    .comp_en   (comp_en),
    .in_valid  (in_valid),
    .enc_ready (enc_ready),
`ifdef JPEG_SEQ_ABORT_EN
    .abort     (abort),
`endif
    .read_en   (read_en),
    .dct_en    (dct_en),
    .encode_en (encode_en),
    .pix_idx   (pix_idx),
    .blk_left  (blk_left),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: a run is "reading" until P pixels are in, then spends
  // LAT DCT cycles, then encodes P coefficients; repeat per block.
  // ---------------------------------------------------------------------------
  int m_stored = 0;
  int m_conf   = 0;   // 1 during the single configuration cycle
  int m_run    = 0;   // 1 while a run is in flight
  int m_blk    = 0;
  int m_rd     = 0;
  int m_dc     = 0;
  int m_en     = 0;
  int m_done   = 0;

  // Observation counters used by the directed scenarios.
  int cyc        = 0;
  int cnt_read   = 0;
  int cnt_dct    = 0;
  int cnt_enc    = 0;
  int cnt_done   = 0;
  int first_read = -1;
  int done_cyc   = -1;
  int bl_q[$];

  always @(negedge clk) begin
    bit e_rd, e_dct, e_enc;
    int e_idx;
    cyc++;
    if (!rst) begin
      m_stored = 0; m_conf = 0; m_run = 0; m_blk = 0;
      m_rd = 0; m_dc = 0; m_en = 0; m_done = 0;
      check("rst_read_en", 32'(read_en), 0);
      check("rst_dct_en", 32'(dct_en), 0);
      check("rst_encode_en", 32'(encode_en), 0);
      check("rst_pix_idx", 32'(pix_idx), 0);
      check("rst_blk_left", 32'(blk_left), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
    end else begin
      e_rd  = (m_run != 0) && (m_rd < P);
      e_dct = (m_run != 0) && (m_rd == P) && (m_dc < LAT);
      e_enc = (m_run != 0) && (m_rd == P) && (m_dc == LAT);
      e_idx = e_rd ? m_rd : (e_enc ? m_en : 0);

      check("read_en", 32'(read_en), 32'(e_rd && in_valid));
      check("dct_en", 32'(dct_en), 32'(e_dct));
      check("encode_en", 32'(encode_en), 32'(e_enc && enc_ready));
      check("blk_left", 32'(blk_left), m_blk);
      check("busy", 32'(busy), 32'(m_run != 0 || m_conf != 0));
      check("done", 32'(done), m_done);
      if (m_run != 0) check("pix_idx", 32'(pix_idx), e_idx);

      if (read_en) cnt_read++;
      if (dct_en) cnt_dct++;
      if (encode_en) cnt_enc++;
      if (read_en && first_read < 0) first_read = cyc;
      if (read_en && pix_idx == 0) bl_q.push_back(int'(blk_left));
      if (done) begin
        cnt_done++;
        done_cyc = cyc;
      end

      // Advance the model with the inputs the DUT will see at the next edge.
      m_done = 0;
      if (m_conf != 0) begin
        m_conf = 0;
      end else if (m_run == 0) begin
        if (conf_en) begin
          m_stored = int'(cfg_blocks);
          m_conf   = 1;
        end else if (comp_en && m_stored != 0) begin
          m_run = 1; m_blk = m_stored; m_rd = 0; m_dc = 0; m_en = 0;
        end
      end else if (abort) begin
        m_run = 0; m_blk = 0; m_rd = 0; m_dc = 0; m_en = 0;
      end else if (e_rd) begin
        if (in_valid) m_rd++;
      end else if (e_dct) begin
        m_dc++;
      end else if (enc_ready) begin
        m_en++;
        if (m_en == P) begin
          m_rd = 0; m_dc = 0; m_en = 0;
          if (m_blk == 1) begin
            m_blk = 0; m_run = 0; m_done = 1;
          end else begin
            m_blk--;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake drivers: 0 low, 1 high, 2 toggle every cycle, 3 random.
  // ---------------------------------------------------------------------------
  int iv_mode = 0;
  int er_mode = 0;

  always @(posedge clk) begin
    #1;
    case (iv_mode)
      0: in_valid = 1'b0;
      1: in_valid = 1'b1;
      2: in_valid = ~in_valid;
      default: in_valid = 1'($urandom_range(0, 1));
    endcase
    case (er_mode)
      0: enc_ready = 1'b0;
      1: enc_ready = 1'b1;
      2: enc_ready = ~enc_ready;
      default: enc_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_obs();
    cnt_read = 0; cnt_dct = 0; cnt_enc = 0; cnt_done = 0;
    first_read = -1; done_cyc = -1;
    bl_q.delete();
  endtask

  task automatic configure(input int blocks);
    conf_en = 1'b1;
    cfg_blocks = CNT_W'(blocks);
    step(1);
    conf_en = 1'b0;
    step(1);
  endtask

  task automatic start_run();
    comp_en = 1'b1;
    step(1);
    comp_en = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    int d0 = cnt_done;
    int k = 0;
    while (cnt_done == d0 && k < max_cyc) begin
      step(1);
      k++;
    end
    check(name, 32'(cnt_done != d0), 1);
  endtask

  initial begin
    rst = 1'b0; conf_en = 1'b0; comp_en = 1'b0; cfg_blocks = '0;
    in_valid = 1'b0; enc_ready = 1'b0; abort = 1'b0;
    step(3);
    rst = 1'b1;
    check("post_reset_busy", 32'(busy), 0);
    check("post_reset_blk_left", 32'(blk_left), 0);

    // Comp_en with stored count 0 must be ignored.
    clear_obs();
    comp_en = 1'b1;
    step(4);
    comp_en = 1'b0;
    step(2);
    check("zero_count_busy", 32'(busy), 0);
    check("zero_count_done", cnt_done, 0);

    // Two blocks with free-flowing handshakes.
    iv_mode = 1; er_mode = 1;
    clear_obs();
    configure(2);
    start_run();
    wait_done("two_blk_done", 400);
    step(3);
    check("two_blk_reads", cnt_read, 128);
    check("two_blk_dct", cnt_dct, 6);
    check("two_blk_encodes", cnt_enc, 128);
    check("two_blk_done_cnt", cnt_done, 1);
    check("two_blk_latency", done_cyc - first_read, 262);
    check("two_blk_bl_len", bl_q.size(), 2);
    if (bl_q.size() == 2) begin
      check("two_blk_bl0", bl_q[0], 2);
      check("two_blk_bl1", bl_q[1], 1);
    end
    check("two_blk_final_blk_left", 32'(blk_left), 0);

    // One block with in_valid toggling every cycle.
    iv_mode = 2;
    clear_obs();
    configure(1);
    start_run();
    wait_done("toggle_done", 400);
    check("toggle_reads", cnt_read, 64);
    check("toggle_dct", cnt_dct, 3);
    check("toggle_encodes", cnt_enc, 64);

    // conf_en wins over comp_en; a later comp_en starts with 5 blocks.
    iv_mode = 1;
    clear_obs();
    conf_en = 1'b1; comp_en = 1'b1; cfg_blocks = CNT_W'(5);
    step(1);
    conf_en = 1'b0; comp_en = 1'b0;
    check("both_conf_busy", 32'(busy), 1);
    check("both_conf_no_read", 32'(read_en), 0);
    step(1);
    check("both_back_idle", 32'(busy), 0);
    step(2);
    start_run();
    check("five_blk_start", 32'(blk_left), 5);
    cfg_blocks = CNT_W'(9);
    conf_en = 1'b1;
    step(2);
    conf_en = 1'b0;
    wait_done("five_blk_done", 5 * 131 + 50);
    check("five_blk_reads", cnt_read, 5 * 64);

    // Reset in the middle of ENCO at pix_idx 30.
    configure(1);
    start_run();
    begin
      int k = 0;
      while (!(encode_en && pix_idx == 30) && k < 300) begin
        step(1);
        k++;
      end
      check("reach_enco_30", 32'(encode_en && pix_idx == 30), 1);
    end
    #1 rst = 1'b0;
    #1;
    check("async_rst_read_en", 32'(read_en), 0);
    check("async_rst_encode_en", 32'(encode_en), 0);
    check("async_rst_pix_idx", 32'(pix_idx), 0);
    check("async_rst_blk_left", 32'(blk_left), 0);
    check("async_rst_busy", 32'(busy), 0);
    step(1);
    rst = 1'b1;
    clear_obs();
    start_run();
    step(3);
    check("after_rst_no_run", 32'(busy), 0);
    check("after_rst_no_read", cnt_read, 0);

`ifdef JPEG_SEQ_ABORT_EN
    // Abort during the DCT of block 1 of 3, then restart.
    clear_obs();
    configure(3);
    start_run();
    begin
      int k = 0;
      while (!(dct_en && blk_left == 3) && k < 200) begin
        step(1);
        k++;
      end
      check("reach_fdct_blk1", 32'(dct_en && blk_left == 3), 1);
    end
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("abort_idle", 32'(busy), 0);
    check("abort_blk_left", 32'(blk_left), 0);
    step(3);
    check("abort_no_done", cnt_done, 0);
    start_run();
    check("abort_restart_blk", 32'(blk_left), 3);
    wait_done("abort_restart_done", 3 * 131 + 50);
`endif

    // Random handshakes with random control noise; the model checks it all.
    iv_mode = 3; er_mode = 3;
    for (int i = 0; i < 4000; i++) begin
      conf_en = ($urandom_range(0, 29) == 0);
      cfg_blocks = CNT_W'($urandom_range(0, 3));
      comp_en = ($urandom_range(0, 4) == 0);
`ifdef JPEG_SEQ_ABORT_EN
      abort = ($urandom_range(0, 149) == 0);
`endif
      step(1);
    end
    conf_en = 1'b0; comp_en = 1'b0; abort = 1'b0;
    step(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/jpeg_block_sequencer.md
Name: jpeg_block_sequencer

Overview:
- Parametrised phase sequencer for the JPEG encoder datapath.
- Sequences a configurable number of blocks through three phases per block: pixel read, forward DCT and entropy encode.
- Produces single-cycle-qualified enables, not gated clocks. Read and encode advance under valid/ready handshakes, so stalls are tolerated.
- Sits between the host configuration interface and the read buffer, DCT and encoder stages.

Parameters:
PIX_PER_BLK, 64, pixels read and coefficients encoded per block (2..256)
DCT_LAT, 3, cycles the DCT stage needs with dct_en high per block (1..16)
CNT_W, 24, width of the block counter
IDX_W, 8, width of pix_idx; must satisfy 2^IDX_W >= PIX_PER_BLK

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
conf_en  in  1  load cfg_blocks (honoured in IDLE only)
cfg_blocks  in  CNT_W  number of blocks to process; 0 means none
comp_en  in  1  start compression (honoured in IDLE only)
in_valid  in  1  read buffer has a pixel this cycle
enc_ready  in  1  encoder accepts a coefficient this cycle
read_en  out  1  pixel accepted this cycle
dct_en  out  1  DCT stage active
encode_en  out  1  coefficient issued to encoder this cycle
pix_idx  out  IDX_W  index within block, 0..PIX_PER_BLK-1, valid in READ/ENCO
blk_left  out  CNT_W  blocks remaining, including the current one
busy  out  1  state is not IDLE
done  out  1  one-cycle pulse after last block encoded

Behaviour:
- Reset (rst=0, async): state=IDLE; stored block count=0; pix_idx=0; blk_left=0; dct_en=0; done=0. read_en and encode_en are 0 because they are gated by state.
- States: IDLE, CONF, READ, FDCT, ENCO.
- IDLE:
  - conf_en=1 -> CONF, capturing cfg_blocks that cycle.
  - else comp_en=1 with stored count!=0 -> READ: blk_left<=count, pix_idx<=0.
  - comp_en with count=0 is ignored; no done pulse.
  - conf_en takes priority over comp_en when both are high.
- CONF: one cycle, then IDLE. The stored count persists across runs; it is not decremented.
- READ:
  - read_en = in_valid (combinational AND with state).
  - Each accepted pixel increments pix_idx.
  - Accepting pixel PIX_PER_BLK-1 -> FDCT with pix_idx<=0.
  - in_valid=0 stalls with no change.
- FDCT:
  - dct_en=1 for exactly DCT_LAT cycles, counted by an internal counter, then -> ENCO.
  - No handshake in this state.
- ENCO:
  - encode_en = enc_ready.
  - Each accepted coefficient increments pix_idx.
  - On coefficient PIX_PER_BLK-1:
    - if blk_left==1 -> IDLE, blk_left<=0, done=1 next cycle.
    - else blk_left decrements, pix_idx<=0, -> READ.
- Latency:
  - Minimum per block = PIX_PER_BLK + DCT_LAT + PIX_PER_BLK cycles, with no idle cycle between phases.
  - Example: 64+3+64 = 131 cycles at defaults.
- Counters:
  - pix_idx never exceeds PIX_PER_BLK-1; no wrap beyond that.
  - blk_left never underflows.
- Inputs ignored while busy: conf_en and comp_en. Changing cfg_blocks mid-run has no effect.
- Reset mid-operation: immediate return to IDLE. All outputs take their reset values and the stored count clears.

Optional Feature:
- Macro: JPEG_SEQ_ABORT_EN.
- Defined:
  - Adds input abort (1 bit).
  - abort=1 in READ, FDCT or ENCO -> IDLE next cycle. pix_idx<=0, blk_left<=0, done is not pulsed, stored count is kept.
  - abort has priority over every other transition. It is ignored in IDLE/CONF.
- Undefined: no abort port. A run completes only by finishing all blocks or by reset.

Test Plan:
- conf_en with cfg_blocks=2, then comp_en, in_valid=1, enc_ready=1 constantly -> read_en high for 64 cycles, dct_en for 3, encode_en for 64, repeated twice. done pulses exactly once, 262 cycles after entering READ; blk_left goes 2 -> 1 -> 0.
- cfg_blocks=1, in_valid toggling 1/0 every cycle -> exactly 64 read_en pulses over 128 READ cycles. pix_idx holds during stalls; FDCT entered after the 64th accept.
- Stored count 0, comp_en=1 -> state stays IDLE, busy=0, done never asserts.
- conf_en and comp_en both high in IDLE with cfg_blocks=5 -> CONF then IDLE. A later comp_en alone starts a run with blk_left=5.
- rst=0 asserted mid-ENCO at pix_idx=30 -> all outputs 0 asynchronously. After release the block stays in IDLE until conf_en is followed by comp_en.
- With JPEG_SEQ_ABORT_EN, abort during FDCT of block 1 of 3 -> IDLE next cycle, no done. comp_en restarts with blk_left=3.
